keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
Scans a 4x3 matrix keypad, debounces key closures and encodes them into the 8421 BCD digit and press strobes consumed by the safe's comparator (data, is_pressed, is_star_pressed). It is the producer end of the keypad-to-comparator interface. It emits exactly one strobe per physical press and holds data stable for the comparator's input register array. It is idle while the safe is off.

Parameters:
SCAN_DWELL, 4, clock cycles each column is driven before advancing (≥2)
DEBOUNCE_CYCLES, 8, consecutive stable synchronized samples required for press and release (≥2)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
is_on  input  1  1 = safe powered on; 0 forces idle
row_in  input  4  keypad rows, active-high; row0=1,2,3 / row1=4,5,6 / row2=7,8,9 / row3=*,0,#
col_out  output  3  one-hot column drive; col0=left, col2=right
data  output  4  BCD code of last accepted digit key
is_pressed  output  1  one-cycle strobe: a digit key was accepted
is_star_pressed  output  1  one-cycle strobe: * accepted
is_hash_pressed  output  1  one-cycle strobe: # accepted

Behaviour:
- Reset: col_out=3'b001, data=4'b0000, all strobes 0, state=SCAN, counters 0, synchronizer flops 0.
- row_in passes through a 2-flop synchronizer (row_s). All decisions use row_s only.
- SCAN state:
  - col_out holds each column for SCAN_DWELL cycles, then rotates 001->010->100->001.
  - On the last dwell cycle, the block samples row_s.
    - Exactly one bit set: capture row index and column, freeze col_out, go to DEBOUNCE with cnt=1.
    - Zero bits: advance column.
    - Multiple bits (ghost/multi-key): treat as no key and advance column.
- DEBOUNCE state:
  - Each cycle row_s equals the captured pattern, cnt increments.
  - Any mismatch: go to SCAN and resume at the next column. No strobe.
  - cnt==DEBOUNCE_CYCLES: go to LOAD.
- LOAD state (1 cycle):
  - Digit key: data <= encoded BCD.
  - * or #: data unchanged.
  - Then go to STROBE.
- STROBE state (1 cycle): assert exactly one of is_pressed / is_star_pressed / is_hash_pressed, then go to HOLD. data is therefore stable ≥1 cycle before and during the strobe.
- HOLD state:
  - col_out stays frozen. rel_cnt counts consecutive cycles with row_s==0; any nonzero row_s clears rel_cnt.
  - rel_cnt==DEBOUNCE_CYCLES: go to SCAN at the next column.
  - A held key never re-strobes (no auto-repeat).
- Encoding (row,col)->data:
  - (0,c)=c+1, (1,c)=c+4, (2,c)=c+7, (3,1)=0.
  - (3,0)=* and (3,2)=# produce no BCD value.
- is_on==0:
  - Synchronously forces state=SCAN, col_out=3'b001, dwell and debounce counters to 0, strobes 0.
  - data retains its value.
  - A key held across an is_on 0->1 transition is accepted as a new press after full debounce.
- Reset asserted mid-operation (any state, including STROBE): all outputs return to reset values immediately; a pending strobe is dropped.
- Strobes are mutually exclusive and never asserted on consecutive cycles.
- Minimum press latency, key in the current column at its sample point: 2 (sync) + DEBOUNCE_CYCLES + 2 cycles to the strobe. Worst case adds 3*SCAN_DWELL.

Test Plan:
- Reset then press key 5 (row1 while col1 driven), stable 40 cycles -> data=4'd5 one cycle before a single 1-cycle is_pressed. No further strobes while held or after release.
- Press 0, then release for ≥DEBOUNCE_CYCLES+2, then press 9 -> two is_pressed strobes with data=0 then data=9. col_out resumes rotation between presses.
- Press * -> one is_star_pressed, data unchanged from the previous digit. Press # -> one is_hash_pressed only.
- Bounce row1 (toggle every 3 cycles for 20 cycles, DEBOUNCE_CYCLES=8), then hold stable -> exactly one is_pressed, issued only after the stable window.
- Rows 0 and 2 high simultaneously in the same column -> no strobe; col_out continues rotating.
- Assert reset during DEBOUNCE, and separately drop is_on during HOLD -> col_out=3'b001, no strobe. After reset, data=0. After the is_on drop, data keeps its prior value. Re-enabling with the key held yields one strobe after debounce.

Source files
------------

// File: rtl/keypad_scanner.sv
// 4x3 matrix keypad scanner: column scan, debounce, BCD encode and one-shot
// press strobes for the safe's code comparator.
module keypad_scanner #(
  parameter int SCAN_DWELL      = 4,
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       is_on,
  input  logic [3:0] row_in,
  output logic [2:0] col_out,
  output logic [3:0] data,
  output logic       is_pressed,
  output logic       is_star_pressed,
  output logic       is_hash_pressed,
  output logic [2:0] state_dbg
);

  localparam int DW = (SCAN_DWELL > 2) ? $clog2(SCAN_DWELL) : 1;
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DWELL - 1);
  localparam logic [CW-1:0] DEB_MAX    = CW'(DEBOUNCE_CYCLES);

  typedef enum logic [2:0] {
    S_SCAN     = 3'd0,
    S_DEBOUNCE = 3'd1,
    S_LOAD     = 3'd2,
    S_STROBE   = 3'd3,
    S_HOLD     = 3'd4
  } state_t;

  state_t        state, state_next;
  logic [3:0]    row_m, row_s, row_cap;
  logic [DW-1:0] dwell_cnt;
  logic [CW-1:0] deb_cnt, rel_cnt;
  logic          dwell_last, row_one_hot, row_match;
  logic [1:0]    row_idx, col_idx;
  logic [3:0]    key_code;
  logic          key_digit, key_star, key_hash;

  assign dwell_last  = (dwell_cnt == DWELL_LAST);
  // A single set bit is the only legal pattern; two or more rows is a ghost.
  assign row_one_hot = (row_s != 4'd0) && ((row_s & (row_s - 4'd1)) == 4'd0);
  assign row_match   = (row_s == row_cap);

  // Column stays frozen from capture to release, so col_out names the key column.
  always_comb begin
    row_idx = 2'd3;
    case (row_cap)
      4'b0001: row_idx = 2'd0;
      4'b0010: row_idx = 2'd1;
      4'b0100: row_idx = 2'd2;
      default: row_idx = 2'd3;
    endcase
    col_idx = 2'd2;
    case (col_out)
      3'b001:  col_idx = 2'd0;
      3'b010:  col_idx = 2'd1;
      default: col_idx = 2'd2;
    endcase
    key_code = 4'd0;
    case (row_idx)
      2'd0:    key_code = {2'b00, col_idx} + 4'd1;
      2'd1:    key_code = {2'b00, col_idx} + 4'd4;
      2'd2:    key_code = {2'b00, col_idx} + 4'd7;
      default: key_code = 4'd0;
    endcase
    key_star  = (row_idx == 2'd3) && (col_idx == 2'd0);
    key_hash  = (row_idx == 2'd3) && (col_idx == 2'd2);
    key_digit = !key_star && !key_hash;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_SCAN;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (!is_on) begin
      state_next = S_SCAN;
    end else begin
      case (state)
        S_SCAN:     if (dwell_last && row_one_hot) state_next = S_DEBOUNCE;
        S_DEBOUNCE: begin
          if (!row_match)              state_next = S_SCAN;
          else if (deb_cnt == DEB_MAX) state_next = S_LOAD;
        end
        S_LOAD:     state_next = S_STROBE;
        S_STROBE:   state_next = S_HOLD;
        S_HOLD:     if (rel_cnt == DEB_MAX) state_next = S_SCAN;
        default:    state_next = S_SCAN;
      endcase
    end
  end

  always_comb begin
    is_pressed      = is_on && (state == S_STROBE) && key_digit;
    is_star_pressed = is_on && (state == S_STROBE) && key_star;
    is_hash_pressed = is_on && (state == S_STROBE) && key_hash;
    state_dbg       = state;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_m     <= 4'd0;
      row_s     <= 4'd0;
      row_cap   <= 4'd0;
      col_out   <= 3'b001;
      dwell_cnt <= '0;
      deb_cnt   <= '0;
      rel_cnt   <= '0;
      data      <= 4'd0;
    end else begin
      row_m <= row_in;
      row_s <= row_m;
      if (!is_on) begin
        col_out   <= 3'b001;
        dwell_cnt <= '0;
        deb_cnt   <= '0;
        rel_cnt   <= '0;
      end else begin
        case (state)
          S_SCAN: begin
            if (dwell_last) begin
              dwell_cnt <= '0;
              if (row_one_hot) begin
                row_cap <= row_s;
                deb_cnt <= CW'(1);
              end else begin
                col_out <= {col_out[1:0], col_out[2]};
              end
            end else begin
              dwell_cnt <= dwell_cnt + 1'b1;
            end
          end
          S_DEBOUNCE: begin
            if (!row_match) begin
              col_out   <= {col_out[1:0], col_out[2]};
              dwell_cnt <= '0;
              deb_cnt   <= '0;
            end else if (deb_cnt == DEB_MAX) begin
              // Load on entry to LOAD so data leads the strobe by a cycle.
              if (key_digit) data <= key_code;
            end else begin
              deb_cnt <= deb_cnt + 1'b1;
            end
          end
          S_STROBE: rel_cnt <= '0;
          S_HOLD: begin
            if (rel_cnt == DEB_MAX) begin
              col_out   <= {col_out[1:0], col_out[2]};
              dwell_cnt <= '0;
              deb_cnt   <= '0;
              rel_cnt   <= '0;
            end else if (row_s != 4'd0) begin
              rel_cnt <= '0;
            end else begin
              rel_cnt <= rel_cnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a physical keypad model drives the rows
// from col_out, and a label-table model predicts every strobe and its data.
module tb_keypad_scanner;
  localparam int SCAN_DWELL = 4;
  localparam int DEB        = 8;
  localparam logic [2:0] ST_DEBOUNCE = 3'd1;

  logic       clk, reset, is_on;
  logic [3:0] row_in;
  logic [2:0] col_out;
  logic [3:0] data;
  logic       is_pressed, is_star_pressed, is_hash_pressed;
  logic [2:0] state_dbg;

  keypad_scanner #(.SCAN_DWELL(SCAN_DWELL), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk(clk), .reset(reset), .is_on(is_on), .row_in(row_in),
    .col_out(col_out), .data(data), .is_pressed(is_pressed),
    .is_star_pressed(is_star_pressed), .is_hash_pressed(is_hash_pressed),
    .state_dbg(state_dbg)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // physical keypad: a closed key connects its column drive to its row
  logic [11:0] key_mask;
  always_comb begin
    row_in = 4'd0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (key_mask[r*3+c] && col_out[c]) row_in[r] = 1'b1;
  end

  // scoreboard: each entry is {kind, data}; kind 1=digit, 2=star, 3=hash
  logic [5:0] exp_q[$];
  string      labels = "123456789*0#";
  logic [3:0] model_digit;
  int checks = 0, failures = 0;
  int strobe_cnt = 0, last_strobe_cyc = 0;
  logic       prev_strobe;
  logic [3:0] prev_data;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_key(input int r, input int c);
    byte ch;
    ch = labels[r*3+c];
    if (ch == "*")      exp_q.push_back({2'd2, model_digit});
    else if (ch == "#") exp_q.push_back({2'd3, model_digit});
    else begin
      model_digit = 4'(ch - "0");
      exp_q.push_back({2'd1, model_digit});
    end
  endtask

  // compare process
  always @(negedge clk) begin
    int nstb, kind;
    logic [5:0] e;
    if (reset) begin
      prev_strobe = 1'b0;
      prev_data   = data;
    end else begin
      chk("col_onehot", $countones(col_out), 1);
      nstb = int'(is_pressed) + int'(is_star_pressed) + int'(is_hash_pressed);
      if (nstb != 0) begin
        chk("one_strobe", nstb, 1);
        chk("no_consecutive", int'(prev_strobe), 0);
        kind = is_pressed ? 1 : (is_star_pressed ? 2 : 3);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_strobe: got kind %0d data %0d expected none (t=%0t)",
                   kind, data, $time);
        end else begin
          e = exp_q.pop_front();
          chk("strobe_kind", kind, int'(e[5:4]));
          chk("strobe_data", int'(data), int'(e[3:0]));
          chk("data_before", int'(prev_data), int'(e[3:0]));
        end
        strobe_cnt++;
        last_strobe_cyc = cyc;
      end
      prev_strobe = (nstb != 0);
      prev_data   = data;
    end
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic drain(input string name, input int budget);
    int i = 0;
    while (exp_q.size() != 0 && i < budget) begin
      step(1);
      i++;
    end
    chk(name, exp_q.size(), 0);
  endtask

  task automatic press(input int r, input int c);
    key_mask[r*3+c] = 1'b1;
  endtask

  initial begin
    int sc0, stable_start, waited;
    logic [2:0] seen;
    reset = 1'b1; is_on = 1'b1; key_mask = '0; model_digit = 4'd0;
    step(3);
    chk("reset_col", int'(col_out), 1);
    chk("reset_data", int'(data), 0);
    chk("reset_strobes", int'({is_pressed, is_star_pressed, is_hash_pressed}), 0);
    reset = 1'b0;
    step(2);

    // key 5, held 40 cycles: one strobe, data 5
    sc0 = strobe_cnt;
    press(1, 1); expect_key(1, 1);
    step(40);
    drain("drain_5", 20);
    chk("data_5", int'(data), 5);
    key_mask = '0;
    step(30);
    chk("single_strobe_5", strobe_cnt - sc0, 1);

    // key 0, release, scan resumes, key 9
    press(3, 1); expect_key(3, 1);
    drain("drain_0", 60);
    chk("data_0", int'(data), 0);
    key_mask = '0;
    step(14);
    seen = 3'b000;
    for (int i = 0; i < 16; i++) begin
      step(1);
      seen |= col_out;
    end
    chk("rotate_after_release", int'(seen), 7);
    press(2, 2); expect_key(2, 2);
    drain("drain_9", 60);
    chk("data_9", int'(data), 9);
    key_mask = '0;
    step(30);

    // star then hash: data unchanged
    press(3, 0); expect_key(3, 0);
    drain("drain_star", 60);
    chk("data_after_star", int'(data), 9);
    key_mask = '0;
    step(30);
    press(3, 2); expect_key(3, 2);
    drain("drain_hash", 60);
    chk("data_after_hash", int'(data), 9);
    key_mask = '0;
    step(30);

    // bouncing key 5, then stable
    for (int i = 0; i < 20; i++) begin
      key_mask[4] = ((i / 3) % 2 == 1);
      step(1);
    end
    press(1, 1);
    stable_start = cyc;
    expect_key(1, 1);
    drain("drain_bounce", 60);
    chk("bounce_after_stable", int'(last_strobe_cyc - stable_start >= DEB), 1);
    key_mask = '0;
    step(30);

    // ghost: rows 0 and 2 in column 0
    sc0 = strobe_cnt;
    press(0, 0); press(2, 0);
    seen = 3'b000;
    for (int i = 0; i < 48; i++) begin
      step(1);
      seen |= col_out;
    end
    chk("ghost_rotates", int'(seen), 7);
    chk("ghost_no_strobe", strobe_cnt - sc0, 0);
    key_mask = '0;
    step(30);

    // reset during debounce of key 3
    sc0 = strobe_cnt;
    press(0, 2);
    waited = 0;
    while (state_dbg != ST_DEBOUNCE && waited < 60) begin
      step(1);
      waited++;
    end
    chk("reached_debounce", int'(state_dbg == ST_DEBOUNCE), 1);
    key_mask = '0;
    reset = 1'b1;
    #1;
    chk("midreset_col", int'(col_out), 1);
    chk("midreset_data", int'(data), 0);
    chk("midreset_strobes", int'({is_pressed, is_star_pressed, is_hash_pressed}), 0);
    model_digit = 4'd0;
    step(3);
    reset = 1'b0;
    step(30);
    chk("post_reset_data", int'(data), 0);
    chk("post_reset_no_strobe", strobe_cnt - sc0, 0);

    // drop is_on during hold of key 8, re-enable with key held
    press(2, 1); expect_key(2, 1);
    drain("drain_8", 60);
    step(3);
    is_on = 1'b0;
    step(1);
    chk("off_col", int'(col_out), 1);
    chk("off_data_kept", int'(data), 8);
    sc0 = strobe_cnt;
    step(9);
    chk("off_col_late", int'(col_out), 1);
    chk("off_no_strobe", strobe_cnt - sc0, 0);
    expect_key(2, 1);
    is_on = 1'b1;
    drain("drain_reenable", 60);
    key_mask = '0;
    step(30);
    chk("reenable_single", strobe_cnt - sc0, 1);

    // final report
    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
